joy_port_responder: RTL and testbench
=====================================

Name: joy_port_responder

Overview:
- Emulates an NES controller, or a Nintendo Four Score, on a physical controller port. An external console drives latch/clock; this block answers on the serial data line.
- It is the responder counterpart to the on-board joystick poller. That poller drives strobe/clock and samples data. This block receives strobe/clock and drives data.
- Button state comes from the FPGA side (poller output, network, replay). Latch/clock arrive asynchronously from the console and are synchronized and deglitched internally.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer (min 2).
- FILT_CYCLES, 4, consecutive identical synchronized samples required before a filtered level changes (1..15).
- SIG_ID, 8'b0000_1000, Four Score signature byte (bits 16..23). Use 8'b0000_0100 for the second port.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- four_score  in  1  1 = 24-bit Four Score frame, 0 = 8-bit standard frame.
- btn_a  in  8  player A buttons, 1 = pressed; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- btn_b  in  8  player B buttons, same encoding; used only in Four Score mode.
- btn_valid  in  1  one-cycle strobe; captures btn_a/btn_b into the snapshot register.
- joy_latch  in  1  console latch pin (async).
- joy_clk  in  1  console clock pin (async, idle high).
- joy_data_n  out  1  data pin, active-low (0 = pressed/logic 1).
- bit_count  out  5  bits shifted out since last latch, saturating.
- frame_done  out  1  one-cycle pulse when bit_count reaches the frame length.

Behaviour:
- Reset (async, reset_n=0):
  - snapshot=0, shreg=0, bit_count=0, frame_done=0, state=IDLE.
  - Filter outputs: latch_f=0, clk_f=1. Synchronizers: latch path 0, clk path 1.
  - joy_data_n=1.
- Input conditioning, per input:
  - SYNC_STAGES-flop synchronizer, then a filter counter.
  - The filtered level takes the synchronized value once it has differed from the current filtered level for FILT_CYCLES consecutive cycles. Any agreeing sample resets the counter.
  - Edges are detected on filtered levels only.
  - Input-to-edge-detect latency is SYNC_STAGES+FILT_CYCLES cycles. Pulses shorter than FILT_CYCLES cycles are rejected.
- Snapshot: on btn_valid, snapshot <= {SIG_ID, btn_b, btn_a}. Otherwise it holds.
- Logical data bit d = shreg[0]. joy_data_n = ~d, registered, so one cycle after shreg changes.
- States:
  - IDLE: after reset, until first latch_f rise. shreg=0, so pin=1.
  - LOAD: while latch_f=1. Every cycle shreg <= snapshot (btn_b/SIG_ID bits forced to 1s-fill-irrelevant? no: loaded as-is) and bit_count <= 0. A btn_valid during LOAD is visible the next cycle, matching 4021 parallel-load transparency.
  - SHIFT: entered on latch_f fall. four_score is sampled here and fixes len = 24 or 8 for the frame.
    - On each clk_f rising edge: shreg <= {1'b1, shreg[23:1]} and bit_count <= bit_count+1.
    - When len=8, the 1-fill takes effect after bit 7 because shreg bits 8..23 are forced to 1 at the latch-fall transition.
    - When bit_count reaches len: one-cycle frame_done pulse, go to DONE.
  - DONE: further clk_f rises keep shifting 1s (d=1, pin=0). bit_count saturates at len; frame_done does not repeat.
- Transitions: latch_f rise from any state -> LOAD, aborting any partial frame with no frame_done. This rule covers re-latch mid-frame.
- clk_f edges during LOAD are ignored. clk_f falling edges never shift.
- Latch fall and clk rise in the same cycle: the latch fall wins; no shift that cycle.
- btn_valid during SHIFT/DONE updates the snapshot only; the frame in flight is unaffected.
- four_score changes mid-frame are ignored until the next latch fall.

Decomposition:
- Shared package joy_pkg:
  - button bit indices (JOY_A..JOY_RIGHT);
  - SIG_PORT0=8'h08, SIG_PORT1=8'h04;
  - FRAME_STD=8, FRAME_FS=24;
  - state encoding (IDLE, LOAD, SHIFT, DONE).
- Sub-module joy_in_filter (parameters SYNC_STAGES, FILT_CYCLES, RESET_VAL): synchronizer plus deglitch, outputs level and rise/fall pulses. Instantiated twice, RESET_VAL 0 for latch and 1 for clk.

Test Plan:
- Reset, no latch -> joy_data_n=1, bit_count=0, frame_done=0; IDLE held for 1000 cycles.
- btn_valid with btn_a=8'h09, four_score=0; latch 200 cycles, 8 clk pulses of 100 cycles each -> pin per bit (logic) 1,0,0,1,0,0,0,0; frame_done once after 8th rise; pulses 9-10 give pin=0.
- four_score=1, btn_a=8'h01, btn_b=8'h80, SIG_ID=8'h08 -> 24 bits: A bit0=1, B bit15=1, signature bit19=1, all others 0; frame_done at bit 24; bit_count=24 saturates.
- 2-cycle glitch on joy_clk in SHIFT (FILT_CYCLES=4) -> no shift, bit_count unchanged; 3-cycle latch glitch -> no reload.
- Re-latch after 5 of 24 bits -> bit_count=0, shreg reloaded, no frame_done; btn_valid with new value during SHIFT -> current frame unchanged, next frame shows it.
- reset_n low mid-SHIFT (bit 10) -> immediate pin=1, bit_count=0, snapshot=0; after release the next frame reads all zeros.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared definitions for the controller-port responder: button bit positions,
// Four Score signature bytes, frame lengths and the responder state encoding.
package joy_pkg;

  localparam int JOY_A      = 0;
  localparam int JOY_B      = 1;
  localparam int JOY_SELECT = 2;
  localparam int JOY_START  = 3;
  localparam int JOY_UP     = 4;
  localparam int JOY_DOWN   = 5;
  localparam int JOY_LEFT   = 6;
  localparam int JOY_RIGHT  = 7;

  localparam logic [7:0] SIG_PORT0 = 8'h08;
  localparam logic [7:0] SIG_PORT1 = 8'h04;

  localparam int FRAME_STD = 8;
  localparam int FRAME_FS  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } joy_state_t;

  // Number of bits in a frame for the selected mode.
  function automatic logic [4:0] frame_len(input logic fs);
    return fs ? 5'(FRAME_FS) : 5'(FRAME_STD);
  endfunction

endpackage

// File: rtl/joy_in_filter.sv
// Synchronizer plus deglitch filter for one console pin. The filtered level
// only moves after FILT_CYCLES consecutive disagreeing synchronized samples;
// rise/fall pulse in the same cycle the level changes.
module joy_in_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [3:0] CNT_TC = 4'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

  // Metastability chain, preset to the pin's idle level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_sync <= {SYNC_STAGES{RESET_VAL}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
  end

  // Down-counter reloads on any agreeing sample; commits the new level at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= CNT_TC;
      r_level <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= CNT_TC;
      end else if (r_cnt == 4'd0) begin
        r_cnt   <= CNT_TC;
        r_level <= w_sync;
        r_rise  <= w_sync;
        r_fall  <= ~w_sync;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/joy_port_responder.sv
// NES controller / Four Score responder: answers a console's latch/clock with
// the button snapshot on an active-low serial data pin.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no latch seen since reset, pin idles high
//   ST_LOAD  | latch high, shift register follows the snapshot
//   ST_SHIFT | latch released, one bit per console clock rise
//   ST_DONE  | frame complete, shifting 1s, bit_count saturated
module joy_port_responder
  import joy_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_CYCLES = 4,
  parameter logic [7:0] SIG_ID      = SIG_PORT0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       four_score,
  input  logic [7:0] btn_a,
  input  logic [7:0] btn_b,
  input  logic       btn_valid,
  input  logic       joy_latch,
  input  logic       joy_clk,
  output logic       joy_data_n,
  output logic [4:0] bit_count,
  output logic       frame_done
);

  logic        w_latch_lvl, w_latch_rise, w_latch_fall;
  logic        w_clk_lvl, w_clk_rise, w_clk_fall;
  logic        w_unused;

  joy_state_t  r_state;
  logic [23:0] r_snapshot;
  logic [23:0] r_shreg;
  logic [4:0]  r_bit_count;
  logic        r_frame_done;
  logic        r_data_n;
  logic        r_fs;

  joy_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES), .RESET_VAL(1'b0)) u_latch_filt (
    .clock   (clock),
    .reset_n (reset_n),
    .i_async (joy_latch),
    .o_level (w_latch_lvl),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  joy_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES), .RESET_VAL(1'b1)) u_clk_filt (
    .clock   (clock),
    .reset_n (reset_n),
    .i_async (joy_clk),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  // Levels and clock falls are not needed: the FSM works purely on edges.
  assign w_unused = &{1'b0, w_latch_lvl, w_clk_lvl, w_clk_fall};

  assign joy_data_n = r_data_n;
  assign bit_count  = r_bit_count;
  assign frame_done = r_frame_done;

  // Button snapshot, updated only by btn_valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       r_snapshot <= 24'd0;
    else if (btn_valid) r_snapshot <= {SIG_ID, btn_b, btn_a};
  end

  // Frame sequencer; a latch rise restarts from any state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shreg      <= 24'd0;
      r_bit_count  <= 5'd0;
      r_frame_done <= 1'b0;
      r_data_n     <= 1'b1;
      r_fs         <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_data_n     <= ~r_shreg[0];
      if (w_latch_rise) begin
        r_state     <= ST_LOAD;
        r_shreg     <= r_snapshot;
        r_bit_count <= 5'd0;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_LOAD: begin
            r_bit_count <= 5'd0;
            if (w_latch_fall) begin
              // Standard frames pre-fill bits 8..23 so 1s follow bit 7.
              r_state <= ST_SHIFT;
              r_fs    <= four_score;
              r_shreg <= four_score ? r_snapshot : {16'hFFFF, r_snapshot[7:0]};
            end else begin
              r_shreg <= r_snapshot;
            end
          end
          ST_SHIFT: begin
            if (w_clk_rise) begin
              r_shreg     <= {1'b1, r_shreg[23:1]};
              r_bit_count <= r_bit_count + 5'd1;
              if (r_bit_count + 5'd1 == frame_len(r_fs)) begin
                r_frame_done <= 1'b1;
                r_state      <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            if (w_clk_rise) r_shreg <= {1'b1, r_shreg[23:1]};
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joy_port_responder.sv
// Bench for joy_port_responder: a console-side driver plus a frame-level model
// (snapshot captured by btn_valid, frame image frozen at latch release).
module tb_joy_port_responder;

  localparam logic [7:0] SIG = 8'h08;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       four_score;
  logic [7:0] btn_a;
  logic [7:0] btn_b;
  logic       btn_valid;
  logic       joy_latch;
  logic       joy_clk;
  logic       joy_data_n;
  logic [4:0] bit_count;
  logic       frame_done;

  int          n_chk = 0;
  int          n_err = 0;
  int          fd_cnt = 0;
  int          fd0 = 0;
  int          fd_save;
  logic [23:0] snap;
  logic [23:0] cur_vec;
  logic        cur_fs;
  int          w;
  int          len;
  int          nr;
  logic [7:0]  ra;
  logic [7:0]  rb;

  joy_port_responder #(.SYNC_STAGES(2), .FILT_CYCLES(4), .SIG_ID(SIG)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .four_score (four_score),
    .btn_a      (btn_a),
    .btn_b      (btn_b),
    .btn_valid  (btn_valid),
    .joy_latch  (joy_latch),
    .joy_clk    (joy_clk),
    .joy_data_n (joy_data_n),
    .bit_count  (bit_count),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_btn(input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    btn_a = a; btn_b = b; btn_valid = 1'b1;
    @(negedge clock);
    btn_valid = 1'b0;
    snap = {SIG, b, a};
  endtask

  // Latch pulse; with coincide the console clock returns high on the same
  // cycle the latch drops.
  task automatic latch_pulse(input int wd, input bit coincide);
    joy_latch = 1'b1;
    cyc(wd);
    if (coincide) begin
      joy_clk = 1'b0;
      cyc(wd);
    end
    cur_vec = snap;
    cur_fs  = four_score;
    fd0     = fd_cnt;
    joy_latch = 1'b0;
    if (coincide) joy_clk = 1'b1;
    cyc(wd);
  endtask

  task automatic clk_pulse(input int wd);
    joy_clk = 1'b0;
    cyc(wd);
    joy_clk = 1'b1;
    cyc(wd);
  endtask

  // Expected pin, count and frame_done after k console clock rises.
  task automatic check_pos(input int k);
    int   l;
    logic e;
    logic ep;
    l  = cur_fs ? 24 : 8;
    e  = (k < l) ? cur_vec[k] : 1'b1;
    ep = ~e;
    chk("pin", 32'(joy_data_n), 32'(ep));
    chk("bit_count", 32'(bit_count), 32'((k < l) ? k : l));
    chk("frame_done", 32'(fd_cnt - fd0), 32'((k >= l) ? 1 : 0));
  endtask

  task automatic run_rises(input int from, input int to, input int wd);
    for (int k = from; k < to; k++) begin
      clk_pulse(wd);
      check_pos(k + 1);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; four_score = 1'b0; btn_a = 8'h00; btn_b = 8'h00;
    btn_valid = 1'b0; joy_latch = 1'b0; joy_clk = 1'b1; snap = 24'd0;
    cur_vec = 24'd0; cur_fs = 1'b0;
    cyc(5);
    reset_n = 1'b1;
    cyc(2);

    // Reset state and idle hold.
    chk("rst_pin", 32'(joy_data_n), 32'd1);
    chk("rst_count", 32'(bit_count), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    cyc(1000);
    chk("idle_pin", 32'(joy_data_n), 32'd1);
    chk("idle_count", 32'(bit_count), 32'd0);
    chk("idle_fd", 32'(fd_cnt), 32'd0);

    // Standard frame, A+Start.
    load_btn(8'h09, 8'h00);
    four_score = 1'b0;
    latch_pulse(200, 1'b0);
    check_pos(0);
    run_rises(0, 10, 50);

    // Four Score frame: A bit0, B bit15, signature bit19.
    load_btn(8'h01, 8'h80);
    four_score = 1'b1;
    latch_pulse(20, 1'b0);
    check_pos(0);
    run_rises(0, 26, 12);

    // Glitches on clock and latch mid-frame are rejected.
    load_btn(8'hA5, 8'h3C);
    latch_pulse(15, 1'b0);
    check_pos(0);
    run_rises(0, 3, 12);
    joy_clk = 1'b0; cyc(2); joy_clk = 1'b1; cyc(15);
    check_pos(3);
    joy_latch = 1'b1; cyc(3); joy_latch = 1'b0; cyc(15);
    check_pos(3);
    run_rises(3, 25, 12);

    // Re-latch after 5 bits aborts; btn_valid in SHIFT waits for next frame.
    load_btn(8'h5A, 8'hC3);
    latch_pulse(15, 1'b0);
    run_rises(0, 5, 12);
    fd_save = fd_cnt;
    latch_pulse(15, 1'b0);
    chk("abort_fd", 32'(fd_cnt), 32'(fd_save));
    check_pos(0);
    run_rises(0, 4, 12);
    load_btn(8'hFF, 8'h11);
    run_rises(4, 24, 12);
    latch_pulse(15, 1'b0);
    check_pos(0);
    run_rises(0, 24, 12);

    // Latch fall and clock rise together: no shift.
    four_score = 1'b0;
    load_btn(8'h82, 8'h00);
    latch_pulse(15, 1'b1);
    check_pos(0);
    run_rises(0, 9, 12);

    // Randomized frames, with occasional mid-frame button or mode changes.
    for (int f = 0; f < 10; f++) begin
      w  = $urandom_range(10, 30);
      ra = 8'($urandom);
      rb = 8'($urandom);
      load_btn(ra, rb);
      four_score = 1'($urandom_range(0, 1));
      latch_pulse(w, 1'($urandom_range(0, 1)));
      len = cur_fs ? 24 : 8;
      nr  = len + $urandom_range(0, 3);
      check_pos(0);
      for (int k = 0; k < nr; k++) begin
        if (k == 2) four_score = 1'($urandom_range(0, 1));
        if (k == 3 && $urandom_range(0, 1) == 1) begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          load_btn(ra, rb);
        end
        clk_pulse(w);
        check_pos(k + 1);
      end
    end

    // Reset mid-frame at bit 10, then an all-zero frame.
    load_btn(8'hFF, 8'hFF);
    four_score = 1'b1;
    latch_pulse(15, 1'b0);
    run_rises(0, 10, 12);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mrst_pin", 32'(joy_data_n), 32'd1);
    chk("mrst_count", 32'(bit_count), 32'd0);
    chk("mrst_done", 32'(frame_done), 32'd0);
    snap = 24'd0;
    cyc(3);
    reset_n = 1'b1;
    cyc(5);
    latch_pulse(15, 1'b0);
    check_pos(0);
    run_rises(0, 26, 12);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
